// File: rtl/multicycle_datapath_if.sv
// Bundle between the control unit/memory and multicycle_datapath: control strobes
// and read data toward the datapath, memory port and status back.
interface multicycle_datapath_if;
  logic        pcen;
  logic        irwrite;
  logic        regwrite;
  logic        alusrca;
  logic        iord;
  logic        memtoreg;
  logic        regdst;
  logic        memwrite;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  op;
  logic        zero;
  logic        carry;

  modport master (
    output pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, memwrite,
    output alusrcb, pcsrc, alucontrol, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, op, zero, carry
  );

  modport slave (
    input  pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, memwrite,
    input  alusrcb, pcsrc, alucontrol, mem_rdata,
    output mem_addr, mem_wdata, mem_we, op, zero, carry
  );
endinterface

// File: rtl/multicycle_datapath.sv
// 16-bit multicycle datapath: PC, IR, MDR, A/B, ALUOut, 8x16 register file, carry flag.
// Optional MDP_DBGPORT_EN adds a combinational register-file debug read port.
module multicycle_datapath #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MDP_DBGPORT_EN
  input  logic [2:0]           dbg_sel,
  output logic [15:0]          dbg_data,
  multicycle_datapath_if.slave bus
`else
  multicycle_datapath_if.slave bus
`endif
);

  logic [15:0] pc, ir, mdr, a_q, b_q, aluout;
  logic        cshadow, carry_q;
  logic [15:0] rf [0:7];

  logic [2:0]  rs, rt, rd, wdest;
  logic [15:0] sx, zx, src_a, src_b, result, pc_next, wdata, rs_val, rt_val;
  logic        c;

  assign rs = ir[11:9];
  assign rt = ir[8:6];
  assign rd = ir[5:3];
  assign sx = {{10{ir[5]}}, ir[5:0]};
  assign zx = {10'd0, ir[5:0]};

  // r0 is hardwired to zero on every read port.
  assign rs_val = (rs == 3'd0) ? 16'd0 : rf[rs];
  assign rt_val = (rt == 3'd0) ? 16'd0 : rf[rt];

  assign src_a = bus.alusrca ? a_q : pc;
  assign wdest = bus.regdst ? rd : rt;
  assign wdata = bus.memtoreg ? mdr : aluout;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    src_b = b_q;
    unique case (bus.alusrcb)
      2'b00: src_b = b_q;
      2'b01: src_b = 16'd1;
      2'b10: src_b = sx;
      2'b11: src_b = zx;
    endcase
  end

  always_comb begin
    result = 16'd0;
    c      = 1'b0;
    unique case (bus.alucontrol)
      3'b000: result = src_a & src_b;
      3'b001: result = src_a | src_b;
      3'b010: {c, result} = {1'b0, src_a} + {1'b0, src_b};
      3'b011: {c, result} = {1'b0, src_a} + {1'b0, ~src_b} + 17'd1;
      3'b100: result = src_a ^ src_b;
      3'b101: result = {15'd0, $signed(src_a) < $signed(src_b)};
      3'b110: begin
        result = {src_a[14:0], 1'b0};
        c      = src_a[15];
      end
      3'b111: begin
        result = {1'b0, src_a[15:1]};
        c      = src_a[0];
      end
    endcase
  end

  always_comb begin
    pc_next = result;
    unique case (bus.pcsrc)
      2'b00: pc_next = result;
      2'b01: pc_next = aluout;
      2'b10: pc_next = {pc[15:12], ir[11:0]};
      2'b11: pc_next = a_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= 16'd0;
      mdr     <= 16'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      aluout  <= 16'd0;
      cshadow <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      mdr     <= bus.mem_rdata;
      a_q     <= rs_val;
      b_q     <= rt_val;
      aluout  <= result;
      cshadow <= c;
      if (bus.irwrite) ir <= bus.mem_rdata;
      if (bus.pcen) pc <= pc_next;
      // Only ALU writebacks move the flag; loads and fetch increments leave it alone.
      if (bus.regwrite && !bus.memtoreg) carry_q <= cshadow;
    end
  end

  // NOTE: the register file sits on the async reset too, since reset must leave every entry at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    end else if (bus.regwrite && (wdest != 3'd0)) begin
      rf[wdest] <= wdata;
    end
  end

`ifdef MDP_DBGPORT_EN
  assign dbg_data = (dbg_sel == 3'd0) ? 16'd0 : rf[dbg_sel];
`endif

  assign bus.mem_addr  = bus.iord ? aluout : pc;
  assign bus.mem_wdata = b_q;
  assign bus.mem_we    = bus.memwrite;
  assign bus.op        = ir[15:12];
  assign bus.zero      = (result == 16'd0);
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath: reset, fetch, ALU ops,
// writeback/carry, load/store, PC sources and register-file corner cases.
module tb_multicycle_datapath;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multicycle_datapath_if bus ();

  multicycle_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  srcb;
    logic [15:0] res;
  } alu_vec_t;

  // A = 16'hBEEF, B = 16'h0001, imm6 = 6'b101010 (sx = FFEA, zx = 002A)
  localparam alu_vec_t ALU_VECS [12] = '{
    '{3'b000, 2'b10, 16'hBEEA},
    '{3'b001, 2'b10, 16'hFFEF},
    '{3'b010, 2'b10, 16'hBED9},
    '{3'b011, 2'b10, 16'hBF05},
    '{3'b100, 2'b10, 16'h4105},
    '{3'b101, 2'b10, 16'h0001},
    '{3'b110, 2'b10, 16'h7DDE},
    '{3'b111, 2'b10, 16'h5F77},
    '{3'b010, 2'b00, 16'hBEF0},
    '{3'b011, 2'b01, 16'hBEEE},
    '{3'b010, 2'b11, 16'hBF19},
    '{3'b000, 2'b11, 16'h002A}
  };

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pcen       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memwrite   = 1'b0;
    bus.alusrcb    = 2'b01;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b010;
    bus.mem_rdata  = 16'd0;
  endtask

  task automatic load_ir(input logic [15:0] word);
    idle();
    bus.mem_rdata = word;
    bus.irwrite   = 1'b1;
    cyc();
    idle();
  endtask

  // Write through the MDR path into rt (memtoreg=1 leaves carry untouched).
  task automatic wr_reg(input logic [2:0] r, input logic [15:0] value);
    load_ir({4'h0, 3'd0, r, 6'd0});
    bus.mem_rdata = value;
    cyc();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    cyc();
    idle();
  endtask

  // Read a register through the B latch onto mem_wdata.
  task automatic check_reg(input string tag, input logic [2:0] r, input logic [15:0] expected);
    load_ir({4'h0, 3'd0, r, 6'd0});
    cyc();
    check(tag, bus.mem_wdata, expected);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_we;
    reset = 1'b0;
    idle();

    // Reset held with random strobes
    for (int i = 0; i < 3; i++) begin
      {bus.pcen, bus.irwrite, bus.regwrite, bus.alusrca,
       bus.iord, bus.memtoreg, bus.regdst, bus.memwrite} = 8'($urandom);
      bus.alusrcb    = 2'($urandom);
      bus.pcsrc      = 2'($urandom);
      bus.alucontrol = 3'($urandom);
      bus.mem_rdata  = 16'($urandom);
      exp_we         = bus.memwrite;
      #1 check("rst_mem_we", bus.mem_we, exp_we);
      cyc();
    end
    idle();
    #1;
    check("rst_pc", bus.mem_addr, 16'h0000);
    check("rst_op", bus.op, 16'h0);
    check("rst_carry", bus.carry, 16'h0);
    check("rst_wdata", bus.mem_wdata, 16'h0000);

    // Release with PC+1
    reset    = 1'b1;
    bus.pcen = 1'b1;
    #1 check("pc_inc_zero", bus.zero, 16'h0);
    cyc();
    check("pc_after_release", bus.mem_addr, 16'h0001);

    // Fetch: op only changes on the edge after irwrite
    idle();
    bus.mem_rdata = 16'h2A58;
    bus.irwrite   = 1'b1;
    bus.pcen      = 1'b1;
    #1 check("op_before_edge", bus.op, 16'h0);
    cyc();
    check("op_fetch", bus.op, 16'h2);
    check("pc_fetch", bus.mem_addr, 16'h0002);
    idle();

    // ADD r1+r2 -> r3 with carry
    wr_reg(3'd1, 16'hFFFF);
    wr_reg(3'd2, 16'h0001);
    load_ir(16'h0298);
    cyc();
    check("b_latch_r2", bus.mem_wdata, 16'h0001);
    bus.alusrca    = 1'b1;
    bus.alusrcb    = 2'b00;
    bus.alucontrol = 3'b010;
    #1 check("add_zero", bus.zero, 16'h1);
    cyc();
    check("carry_before_wb", bus.carry, 16'h0);
    bus.iord = 1'b1;
    #1 check("add_aluout", bus.mem_addr, 16'h0000);
    bus.iord     = 1'b0;
    bus.regwrite = 1'b1;
    bus.regdst   = 1'b1;
    cyc();
    check("carry_after_wb", bus.carry, 16'h1);
    idle();
    bus.pcen = 1'b1;
    cyc();
    check("carry_after_fetch", bus.carry, 16'h1);
    check("pc_fetch2", bus.mem_addr, 16'h0003);
    idle();
    check_reg("r3_add", 3'd3, 16'h0000);

    // Store then load
    load_ir(16'h047F);
    cyc();
    bus.alusrca    = 1'b1;
    bus.alusrcb    = 2'b11;
    bus.alucontrol = 3'b010;
    #1 check("addr_calc_zero", bus.zero, 16'h0);
    cyc();
    bus.iord     = 1'b1;
    bus.memwrite = 1'b1;
    #1;
    check("st_addr", bus.mem_addr, 16'h0040);
    check("st_we", bus.mem_we, 16'h1);
    check("st_wdata", bus.mem_wdata, 16'hFFFF);
    bus.memwrite  = 1'b0;
    bus.mem_rdata = 16'hBEEF;
    cyc();
    check("ld_we", bus.mem_we, 16'h0);
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    bus.regdst   = 1'b0;
    cyc();
    check("ld_carry_held", bus.carry, 16'h1);
    idle();
    check_reg("r1_load", 3'd1, 16'hBEEF);

    // ALU table through ALUOut
    load_ir(16'h02AA);
    cyc();
    for (int i = 0; i < 12; i++) begin
      bus.alusrca    = 1'b1;
      bus.iord       = 1'b1;
      bus.alucontrol = ALU_VECS[i].op;
      bus.alusrcb    = ALU_VECS[i].srcb;
      cyc();
      check($sformatf("alu_%0d", i), bus.mem_addr, ALU_VECS[i].res);
    end

    // SUB with borrow -> rd=5, carry cleared
    bus.iord       = 1'b0;
    bus.alucontrol = 3'b011;
    bus.alusrcb    = 2'b10;
    cyc();
    bus.regwrite = 1'b1;
    bus.regdst   = 1'b1;
    cyc();
    check("sub_carry", bus.carry, 16'h0);
    idle();
    check_reg("r5_sub", 3'd5, 16'hBF05);

    // Equal operands: SUB and SLT give zero, OR does not
    load_ir(16'h0480);
    cyc();
    bus.alusrca    = 1'b1;
    bus.alusrcb    = 2'b00;
    bus.alucontrol = 3'b011;
    #1 check("sub_eq_zero", bus.zero, 16'h1);
    bus.alucontrol = 3'b101;
    #1 check("slt_eq_zero", bus.zero, 16'h1);
    bus.alucontrol = 3'b001;
    #1 check("or_nonzero", bus.zero, 16'h0);
    idle();

    // PC sources
    wr_reg(3'd6, 16'h5003);
    load_ir(16'h0C00);
    cyc();
    bus.pcen  = 1'b1;
    bus.pcsrc = 2'b11;
    cyc();
    check("pc_from_a", bus.mem_addr, 16'h5003);
    idle();
    load_ir(16'h7123);
    check("op_jump", bus.op, 16'h7);
    bus.pcen  = 1'b1;
    bus.pcsrc = 2'b10;
    cyc();
    check("pc_jump", bus.mem_addr, 16'h5123);
    idle();
    wr_reg(3'd7, 16'h0777);
    load_ir(16'h0E00);
    cyc();
    bus.pcen  = 1'b1;
    bus.pcsrc = 2'b11;
    cyc();
    check("pc_jr", bus.mem_addr, 16'h0777);
    idle();
    bus.alusrca = 1'b1;
    cyc();
    bus.pcen       = 1'b1;
    bus.pcsrc      = 2'b01;
    bus.alucontrol = 3'b000;
    bus.alusrcb    = 2'b00;
    cyc();
    check("pc_from_aluout", bus.mem_addr, 16'h0778);
    idle();

    // PC wrap
    load_ir(16'h0000);
    cyc();
    bus.alusrca    = 1'b1;
    bus.alucontrol = 3'b011;
    bus.pcen       = 1'b1;
    cyc();
    check("pc_ffff", bus.mem_addr, 16'hFFFF);
    bus.alusrca    = 1'b0;
    bus.alucontrol = 3'b010;
    #1 check("wrap_zero", bus.zero, 16'h1);
    cyc();
    check("pc_wrap", bus.mem_addr, 16'h0000);
    idle();

    // r0 discards writes
    wr_reg(3'd0, 16'h1234);
    check_reg("r0_zero", 3'd0, 16'h0000);

    // Same-edge write and capture of r4 keeps the old value
    wr_reg(3'd4, 16'h1111);
    load_ir(16'h0900);
    bus.mem_rdata = 16'h2222;
    cyc();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    cyc();
    check("same_edge_b_old", bus.mem_wdata, 16'h1111);
    idle();
    bus.pcen  = 1'b1;
    bus.pcsrc = 2'b11;
    cyc();
    check("same_edge_a_old", bus.mem_addr, 16'h1111);
    check("same_edge_b_new", bus.mem_wdata, 16'h2222);
    idle();

    // Reset during a writeback cycle
    load_ir(16'h00C0);
    bus.mem_rdata = 16'hABCD;
    cyc();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    #2 reset = 1'b0;
    cyc();
    check("rst_mid_pc", bus.mem_addr, 16'h0000);
    check("rst_mid_op", bus.op, 16'h0);
    idle();
    reset = 1'b1;
    check_reg("rst_mid_r3", 3'd3, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multicycle datapath consuming the strobes and selects produced by the processor control unit. It holds the PC, instruction register (IR), memory data register (MDR), A/B operand latches, ALUOut, an 8-entry register file and a carry flag. It returns the opcode plus zero/carry status to the control unit and drives the unified instruction/data memory port. All words are 16 bits, and memory is word-addressed.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, memwrite  in  1 each  control strobes/selects
- alusrcb  in  2  ALU B-source select
- pcsrc  in  2  next-PC select
- alucontrol  in  3  ALU operation
- mem_rdata  in  16  memory read data, combinational from mem_addr
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data (= B latch)
- mem_we  out  1  = memwrite
- op  out  4  IR[15:12]
- zero  out  1  combinational: current ALU result == 0
- carry  out  1  architectural carry flag (registered)

## Operation
- IR fields: op[15:12], rs[11:9], rt[8:6], rd[5:3], imm6[5:0]. sx = sign-extended imm6; zx = zero-extended imm6.
- srcA: alusrca 0 → PC; 1 → A.
- srcB: 00 → B; 01 → 16'd1; 10 → sx; 11 → zx.
- alucontrol behaviour (internal carry-out c):
  - 000 AND, c=0
  - 001 OR, c=0
  - 010 ADD, c=17th bit
  - 011 SUB = a+~b+1, c=17th bit (1 = no borrow)
  - 100 XOR, c=0
  - 101 SLT signed (1/0), c=0
  - 110 SHL1, c=a[15]
  - 111 SHR1 logical, c=a[0]
- Registers updated every edge: MDR←mem_rdata; A←rf[rs]; B←rf[rt]; ALUOut←result; Cshadow←c.
- IR←mem_rdata only when irwrite=1.
- PC loads only when pcen=1, from the pcsrc selection:
  - 00 → ALU result
  - 01 → ALUOut
  - 10 → {PC[15:12], IR[11:0]}
  - 11 → A
- mem_addr: iord 0 → PC; 1 → ALUOut.
- Register write on regwrite=1:
  - destination: regdst 0 → rt; 1 → rd
  - data: memtoreg 0 → ALUOut; 1 → MDR
- r0 reads as 0. Writes to r0 are discarded.
- carry flag←Cshadow when regwrite=1 and memtoreg=0; otherwise it holds. Fetch-phase PC increments therefore never disturb it.

## Timing
- Reset (asynchronous assert, synchronous-edge release): PC=RESET_PC; IR, MDR, A, B, ALUOut, Cshadow, carry and all rf entries = 0.
  - Outputs under reset: op=0, carry=0, mem_addr=RESET_PC or 0 depending on iord, mem_wdata=0.
  - mem_we follows memwrite even during reset.
- Reset asserted mid-instruction aborts it immediately. No partial register-file write completes after the reset edge.
- Register file: combinational read, write on rising edge. Same-edge write and A/B capture of the same register latches the OLD value.
- zero has zero latency: valid in the same cycle as srcA/srcB/alucontrol, so the control unit can use branch&zero in that cycle.
- carry has one-cycle latency after the writeback edge.
- op changes only on the edge after irwrite=1.
- No stall or handshake: memory must return read data in the same cycle. Writes commit on the edge where mem_we=1.
- PC arithmetic wraps modulo 2^16 (16'hFFFF+1 → 0).

## Configuration
- MDP_DBGPORT_EN defined: adds input dbg_sel[2:0] and output dbg_data[15:0], a combinational third read port of the register file (dbg_sel=0 → 0). It has no side effects on state.
- Undefined: both ports are absent, and register file behaviour is identical.

## Test plan
- Reset: hold reset=0 with random strobes for 3 cycles → PC=0, op=0, carry=0, mem_addr=0 (iord=0). Release with pcen=1, pcsrc=00, alusrca=0, alusrcb=01 → PC=1 after the first edge.
- Fetch/decode: mem_rdata=16'h2A58 with irwrite=1 → op=4'h2 next cycle. rs=5 and rt=1 select A/B on the following edge.
- ADD writeback with carry: r1=16'hFFFF, r2=16'h0001, alucontrol=010 → zero=1 in the execute cycle. After regwrite (memtoreg=0, regdst=1, rd=3): r3=0, carry=1. A later fetch cycle with PC+1 (c=0) leaves carry=1.
- Load/store: ALUOut=16'h0040, iord=1, memwrite=1 → mem_addr=16'h0040, mem_we=1, mem_wdata=B. Read path: mem_rdata=16'hBEEF → MDR; memtoreg=1 writeback → rt=16'hBEEF, carry unchanged.
- Branch/jump: SUB of equal operands → zero=1. pcsrc=10 with PC=16'h5003, IR[11:0]=12'h123 → PC=16'h5123. pcsrc=11 with A=16'h0777 → PC=16'h0777.
- Corner cases:
  - write r0=16'h1234 → reads 0
  - same-edge write/read of r4 → A gets old value
  - reset asserted during a writeback cycle → r-file entry stays 0
